// File: rtl/cpu_sequencer_pkg.sv
// Shared opcodes, sequencer state encoding and phase-strobe vector for the
// 16-bit accumulator CPU sequencer.
package cpu_pkg;

  localparam logic [4:0] OP_INP = 5'b11101;
  localparam logic [4:0] OP_OTP = 5'b11110;
  localparam logic [4:0] OP_JMP = 5'b11100;

  typedef enum logic [2:0] {
    ST_HALT,
    ST_FETCH,
    ST_WAIT_IN,
    ST_EXEC1,
    ST_EXEC2,
    ST_WAIT_OUT,
    ST_EXEC3
  } state_t;

  typedef struct packed {
    logic fetch;
    logic exec1;
    logic exec2;
    logic exec3;
  } phase_t;

  // Wait states and HALT map to an all-zero vector so the decoder stays idle.
  function automatic phase_t phase_of(input state_t s);
    phase_t p;
    p = '0;
    case (s)
      ST_FETCH: p.fetch = 1'b1;
      ST_EXEC1: p.exec1 = 1'b1;
      ST_EXEC2: p.exec2 = 1'b1;
      ST_EXEC3: p.exec3 = 1'b1;
      default:  p = '0;
    endcase
    return p;
  endfunction

  function automatic logic [4:0] opcode_of(input logic [15:0] word);
    return word[15:11];
  endfunction

endpackage

// File: rtl/cpu_sequencer_reset_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on the
// second rising clock edge after rst_n goes high.
module reset_sync (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta       <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      meta       <= 1'b1;
      rst_sync_n <= meta;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Phase sequencer: walks fetch/exec phases per instruction, stalls on I/O
// handshakes, and provides run/halt/single-step control with a retire counter.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step_req,
  input  logic [15:0]      rom_q,
  input  logic             extra,
  input  logic             extra2,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic [15:0]      instr,
  output logic             fetch,
  output logic             exec1,
  output logic             exec2,
  output logic             exec3,
  output logic             in_ack,
  output logic             out_valid,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  logic   rst_sync_n;
  state_t state;
  state_t state_nx;
  logic   step;
  logic   step_nx;
  logic   done;
  logic   ack_nx;
  logic   ov_nx;
  phase_t phase;

  reset_sync u_reset_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_sync_n (rst_sync_n)
  );

  always_comb begin
    state_nx = state;
    step_nx  = step;
    done     = 1'b0;
    ack_nx   = 1'b0;
    ov_nx    = 1'b0;
    case (state)
      ST_HALT: begin
        if (run) begin
          state_nx = ST_FETCH;
        end else if (step_req) begin
          state_nx = ST_FETCH;
          step_nx  = 1'b1;
        end
      end
      ST_FETCH:
        state_nx = (opcode_of(rom_q) == OP_INP) ? ST_WAIT_IN : ST_EXEC1;
      // INP is the only path into EXEC1 via WAIT_IN, so the ack rides that edge.
      ST_WAIT_IN: begin
        if (in_valid) begin
          state_nx = ST_EXEC1;
          ack_nx   = 1'b1;
        end
      end
      ST_EXEC1: begin
        if (extra)
          state_nx = (opcode_of(instr) == OP_OTP) ? ST_WAIT_OUT : ST_EXEC2;
        else
          done = 1'b1;
      end
      ST_WAIT_OUT: begin
        if (out_ready) begin
          state_nx = ST_EXEC2;
          ov_nx    = 1'b1;
        end
      end
      ST_EXEC2: begin
        if (extra2) state_nx = ST_EXEC3;
        else        done     = 1'b1;
      end
      ST_EXEC3: done = 1'b1;
      default:  state_nx = ST_HALT;
    endcase
    // A pending single step always returns to HALT once its instruction retires.
    if (done) begin
      state_nx = (run && !step) ? ST_FETCH : ST_HALT;
      step_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state       <= ST_HALT;
      step        <= 1'b0;
      instr       <= '0;
      instr_count <= '0;
      phase       <= '0;
      halted      <= 1'b1;
      in_ack      <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      state     <= state_nx;
      step      <= step_nx;
      phase     <= phase_of(state_nx);
      halted    <= (state_nx == ST_HALT);
      in_ack    <= ack_nx;
      out_valid <= ov_nx;
      if (state == ST_FETCH) instr <= rom_q;
      if (done) instr_count <= instr_count + CNT_W'(1);
    end
  end

  assign fetch = phase.fetch;
  assign exec1 = phase.exec1;
  assign exec2 = phase.exec2;
  assign exec3 = phase.exec3;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Phase sequencer for the 16-bit accumulator CPU. It drives the one-hot `fetch`/`exec1`/`exec2`/`exec3` phase strobes that the instruction decoder consumes, and consumes the decoder's `extra`/`extra2` length hints in return. It holds the instruction register, stalls on the input/output device handshakes, and provides run/halt/single-step control and a retired-instruction counter. It sits between program ROM, the decoder and the I/O ports.

## Interface
- `CNT_W`, 16, width of `instr_count`
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `run`  in  1  level; 1 = execute continuously
- `step_req`  in  1  one-cycle pulse; executes one instruction while halted
- `rom_q`  in  16  ROM data at current PC, valid during `fetch`
- `extra`  in  1  from decoder; instruction needs `exec2`
- `extra2`  in  1  from decoder; instruction needs `exec3`
- `in_valid`  in  1  input device holds a word
- `out_ready`  in  1  output device can accept a word
- `instr`  out  16  instruction register, feeds decoder
- `fetch`, `exec1`, `exec2`, `exec3`  out  1 each  phase strobes, at most one high
- `in_ack`  out  1  input word consumed this cycle
- `out_valid`  out  1  output word presented this cycle
- `halted`  out  1  sequencer idle at an instruction boundary
- `instr_count`  out  CNT_W  retired instructions, wraps

## Operation
- States: HALT, FETCH, WAIT_IN, EXEC1, EXEC2, WAIT_OUT, EXEC3. Phase strobes, `halted`, `in_ack` and `out_valid` are registered, decoded from the state flops, and never glitch.
- HALT: `halted`=1. If `run`=1, go to FETCH. If `run`=0 and `step_req`=1, go to FETCH with the step flag set.
- FETCH: `fetch`=1. Latch `rom_q` into `instr` at the end of the cycle. If the new opcode `rom_q[15:11]` = INP (11101), go to WAIT_IN. Otherwise go to EXEC1.
- WAIT_IN: all strobes are low, so the decoder asserts no enables. Stay until `in_valid`=1, then go to EXEC1.
- EXEC1: `exec1`=1. `in_ack`=1 if `instr` is INP. If `extra`=1, go to WAIT_OUT when `instr[15:11]` = OTP (11110), else to EXEC2. Otherwise the instruction ends.
- WAIT_OUT: all strobes low. Stay until `out_ready`=1, then go to EXEC2.
- EXEC2: `exec2`=1. `out_valid`=1 if `instr` is OTP. If `extra2`=1, go to EXEC3; otherwise the instruction ends.
- EXEC3: `exec3`=1. The instruction ends.
- At instruction end: `instr_count` += 1, wrapping modulo 2^CNT_W. Next state is FETCH if `run`=1 and the step flag is clear; otherwise HALT, and the step flag clears.
- `run` falling mid-instruction does not abort the instruction; it completes, then the sequencer halts.
- `step_req` outside HALT is ignored.
- `extra`/`extra2` are sampled only in EXEC1/EXEC2 respectively, from the already-latched `instr`.

## Timing
- Reset, asynchronous: state HALT, `instr`=0, `instr_count`=0, `halted`=1, and all strobes, `in_ack` and `out_valid` = 0. Deassertion is synchronized internally (2-flop) so that the first edge after release is clean.
- Cycles per instruction, no stalls:
  - LDI, STA, JEQ, JMP, regwork: 2 cycles
  - LDA, STN, OTP: 3 cycles
  - LDN, ADN: 4 cycles
  - INP: 2 cycles plus WAIT_IN cycles
  - OTP: additionally plus WAIT_OUT cycles
- HALT→FETCH takes 1 cycle after `run` or `step_req` is sampled.
- Back-to-back instructions have no bubble: the end phase is followed directly by FETCH.
- `in_valid` already high in WAIT_IN means exactly one WAIT_IN cycle. WAIT_IN and WAIT_OUT always cost at least one cycle.
- `in_ack` and `out_valid` are each high for exactly one cycle per INP/OTP.
- Reset asserted mid-instruction drops all strobes immediately, with no completion and no count.

## Structure
- Package `cpu_pkg`:
  - opcode constants: OP_INP=5'b11101, OP_OTP=5'b11110, OP_JMP=5'b11100
  - state enum
  - phase-vector typedef
- One sub-module, `reset_sync`: a 2-flop async-assert/sync-deassert synchronizer.

## Test plan
- Reset with `run`=1, ROM=0x8000 (LDI, decoder `extra`=0): fetch, exec1, fetch, exec1 repeating; `instr_count` increments every 2 cycles.
- ROM=0x4000 (LDN, `extra`=`extra2`=1): fetch→exec1→exec2→exec3→fetch in 4 cycles; exactly one strobe high in each cycle.
- ROM=0xE800 (INP), `in_valid` low for 5 cycles then high: WAIT_IN for 5 cycles with all strobes 0, then exec1 with `in_ack`=1 for one cycle; count +1.
- ROM=0xF000 (OTP, `extra`=1), `out_ready`=0 for 3 cycles: exec1, 3× WAIT_OUT, exec2 with `out_valid`=1; no exec3.
- `run`=0, pulse `step_req` with ROM=0x0000 (LDA): exactly fetch, exec1, exec2, then `halted`=1 and count=1. A second `step_req` pulse during exec1 is ignored.
- Assert `rst_n`=0 during exec2 of LDN: strobes drop the same cycle, `instr`=0, count=0. After release with `run`=1, the first non-HALT state is FETCH.
